// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. It handles load-use stalls, mispredict flushes, the
// multi-cycle EX handshake with its watchdog, and the sticky halt. `define STALL_PERF_EN for perf counters.
module pipeline_hazard_controller #(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           rs1_id,
   input  logic [4:0]           rs2_id,
   input  logic                 use_rs1_id,
   input  logic                 use_rs2_id,
   input  logic [4:0]           rd_ex,
   input  logic                 mem_read_ex,
   input  logic                 mc_valid_ex,
   input  logic                 mc_done,
   input  logic                 mispredict_ex,
   input  logic                 halt_wb,
   output logic                 pc_write,
   output logic                 if_id_write,
   output logic                 if_id_flush,
   output logic                 id_ex_write,
   output logic                 id_ex_bubble,
   output logic                 ex_mem_bubble,
   output logic                 mc_start,
   output logic                 mc_abort,
   output logic                 mc_timeout_err,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] load_stall_cnt,
   output logic [CNT_WIDTH-1:0] mc_stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   localparam int WD_W = $clog2(MC_TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MC_BUSY = 2'd1,
      HALT    = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [WD_W-1:0] watchdog_q, watchdog_d;
   logic            halted_q, halted_d;
   logic            timeout_err_q, timeout_err_d;
   logic            load_stall_q, load_stall_d;
   logic            load_use_hit;
   logic            load_stall;

   assign load_use_hit = mem_read_ex && (rd_ex != 5'd0) &&
                         ((use_rs1_id && (rs1_id == rd_ex)) ||
                          (use_rs2_id && (rs2_id == rd_ex)));

   // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      watchdog_d    = watchdog_q;
      halted_d      = halted_q;
      timeout_err_d = timeout_err_q;
      load_stall    = 1'b0;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      mc_start      = 1'b0;
      mc_abort      = 1'b0;

      if (reset) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         id_ex_bubble  = 1'b1;
         ex_mem_bubble = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (halt_wb) begin
                  pc_write      = 1'b0;
                  if_id_write   = 1'b0;
                  id_ex_write   = 1'b0;
                  id_ex_bubble  = 1'b1;
                  ex_mem_bubble = 1'b1;
                  state_d       = HALT;
                  halted_d      = 1'b1;
               end else if (mispredict_ex) begin
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
               end else if (mc_valid_ex) begin
                  mc_start      = 1'b1;
                  pc_write      = 1'b0;
                  if_id_write   = 1'b0;
                  id_ex_write   = 1'b0;
                  ex_mem_bubble = 1'b1;
                  watchdog_d    = WD_W'(1);
                  state_d       = MC_BUSY;
               end else if (load_use_hit && !load_stall_q) begin
                  // The hazard is cleared after one bubble, so a held hazard never stalls twice in a row.
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  load_stall   = 1'b1;
               end
            end

            MC_BUSY: begin
               pc_write      = 1'b0;
               if_id_write   = 1'b0;
               id_ex_write   = 1'b0;
               ex_mem_bubble = 1'b1;
               watchdog_d    = watchdog_q + WD_W'(1);
               if (halt_wb) begin
                  mc_abort     = 1'b1;
                  id_ex_bubble = 1'b1;
                  watchdog_d   = '0;
                  state_d      = HALT;
                  halted_d     = 1'b1;
               end else if (mc_done) begin
                  pc_write      = 1'b1;
                  if_id_write   = 1'b1;
                  id_ex_write   = 1'b1;
                  ex_mem_bubble = 1'b0;
                  watchdog_d    = '0;
                  state_d       = RUN;
               end else if (watchdog_q == WD_W'(MC_TIMEOUT)) begin
                  // The op is dropped: its EX/MEM slot stays a bubble while the front end resumes.
                  mc_abort      = 1'b1;
                  timeout_err_d = 1'b1;
                  pc_write      = 1'b1;
                  if_id_write   = 1'b1;
                  id_ex_write   = 1'b1;
                  watchdog_d    = '0;
                  state_d       = RUN;
               end
            end

            HALT: begin
               pc_write      = 1'b0;
               if_id_write   = 1'b0;
               id_ex_write   = 1'b0;
               id_ex_bubble  = 1'b1;
               ex_mem_bubble = 1'b1;
            end

            default: state_d = RUN;
         endcase
      end

      load_stall_d = load_stall;
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and active-high.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RUN;
         watchdog_q    <= '0;
         halted_q      <= 1'b0;
         timeout_err_q <= 1'b0;
         load_stall_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         watchdog_q    <= watchdog_d;
         halted_q      <= halted_d;
         timeout_err_q <= timeout_err_d;
         load_stall_q  <= load_stall_d;
      end
   end

   assign halted         = halted_q;
   assign mc_timeout_err = timeout_err_q;

`ifdef STALL_PERF_EN
   logic [CNT_WIDTH-1:0] load_stall_cnt_q, load_stall_cnt_d;
   logic [CNT_WIDTH-1:0] mc_stall_cnt_q, mc_stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
   logic                 mc_stall_cyc;

   // An MC stall cycle is any non-reset cycle whose next state is MC_BUSY, which covers the entry cycle
   // and every busy cycle except the exit.
   assign mc_stall_cyc = !reset && (state_d == MC_BUSY);

   always_comb begin
      load_stall_cnt_d = load_stall_cnt_q;
      mc_stall_cnt_d   = mc_stall_cnt_q;
      flush_cnt_d      = flush_cnt_q;
      if (load_stall && (load_stall_cnt_q != '1)) load_stall_cnt_d = load_stall_cnt_q + 1'b1;
      if (mc_stall_cyc && (mc_stall_cnt_q != '1)) mc_stall_cnt_d = mc_stall_cnt_q + 1'b1;
      if (if_id_flush && (flush_cnt_q != '1))     flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         load_stall_cnt_q <= '0;
         mc_stall_cnt_q   <= '0;
         flush_cnt_q      <= '0;
      end else begin
         load_stall_cnt_q <= load_stall_cnt_d;
         mc_stall_cnt_q   <= mc_stall_cnt_d;
         flush_cnt_q      <= flush_cnt_d;
      end
   end

   assign load_stall_cnt = load_stall_cnt_q;
   assign mc_stall_cnt   = mc_stall_cnt_q;
   assign flush_cnt      = flush_cnt_q;
`else
   assign load_stall_cnt = '0;
   assign mc_stall_cnt   = '0;
   assign flush_cnt      = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: the driver pushes hand-computed expectations per cycle,
// and the monitor pops and compares them on the falling edge.
module tb_pipeline_hazard_controller;

   localparam int MC_TIMEOUT = 4;
   localparam int CW         = 2;
`ifdef STALL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, mc_start, mc_abort}
   localparam logic [7:0] C_RUN    = 8'b1101_0000;
   localparam logic [7:0] C_RST    = 8'b0000_1100;
   localparam logic [7:0] C_HALT   = 8'b0000_1100;
   localparam logic [7:0] C_LOAD   = 8'b0001_1000;
   localparam logic [7:0] C_FLUSH  = 8'b1111_1000;
   localparam logic [7:0] C_MCENT  = 8'b0000_0110;
   localparam logic [7:0] C_MCBSY  = 8'b0000_0100;
   localparam logic [7:0] C_MCTO   = 8'b1101_0101;
   localparam logic [7:0] C_MCHALT = 8'b0000_1101;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    rs1_id, rs2_id, rd_ex;
   logic          use_rs1_id, use_rs2_id, mem_read_ex, mc_valid_ex, mc_done, mispredict_ex, halt_wb;
   logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble;
   logic          mc_start, mc_abort, mc_timeout_err, halted;
   logic [CW-1:0] load_stall_cnt, mc_stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
      .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .mc_valid_ex(mc_valid_ex), .mc_done(mc_done),
      .mispredict_ex(mispredict_ex), .halt_wb(halt_wb),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
      .mc_start(mc_start), .mc_abort(mc_abort), .mc_timeout_err(mc_timeout_err), .halted(halted),
      .load_stall_cnt(load_stall_cnt), .mc_stall_cnt(mc_stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct {
      string         name;
      logic [7:0]    ctrl;
      logic          err;
      logic          hlt;
      logic [CW-1:0] ld;
      logic [CW-1:0] mc;
      logic [CW-1:0] fl;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   int            tests_run    = 0;
   int            tests_failed = 0;
   logic          e_err = 1'b0, e_hlt = 1'b0;
   logic [CW-1:0] e_ld = '0, e_mc = '0, e_fl = '0;

   task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + 1'b1;
   endfunction

   task automatic idle();
      reset = 1'b0; rs1_id = '0; rs2_id = '0; rd_ex = '0;
      use_rs1_id = 1'b0; use_rs2_id = 1'b0; mem_read_ex = 1'b0;
      mc_valid_ex = 1'b0; mc_done = 1'b0; mispredict_ex = 1'b0; halt_wb = 1'b0;
   endtask

   task automatic load_use(input logic [4:0] r);
      mem_read_ex = 1'b1; rd_ex = r; rs1_id = r; use_rs1_id = 1'b1;
   endtask

   // Queue the expectation for the cycle whose inputs are now applied, then advance one clock.
   task automatic cyc(input string nm, input logic [7:0] ctrl);
      exp_t e;
      e.name = nm; e.ctrl = ctrl; e.err = e_err; e.hlt = e_hlt;
      e.ld = PERF ? e_ld : '0;
      e.mc = PERF ? e_mc : '0;
      e.fl = PERF ? e_fl : '0;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic clr_all();
      e_err = 1'b0; e_hlt = 1'b0; e_ld = '0; e_mc = '0; e_fl = '0;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check({mon_e.name, "/ctrl"},
               {6'd0, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble,
                mc_start, mc_abort, mc_timeout_err, halted},
               {6'd0, mon_e.ctrl, mon_e.err, mon_e.hlt});
         check({mon_e.name, "/cnt"},
               {{(16-3*CW){1'b0}}, load_stall_cnt, mc_stall_cnt, flush_cnt},
               {{(16-3*CW){1'b0}}, mon_e.ld, mon_e.mc, mon_e.fl});
      end
   end

   initial begin
      idle(); reset = 1'b1;
      @(posedge clk); #1;
      cyc("rst0", C_RST);
      cyc("rst1", C_RST);

      idle(); cyc("run_idle", C_RUN);
      load_use(5'd5); cyc("lu_rs1", C_LOAD); e_ld = sat(e_ld);
      cyc("lu_held_once", C_RUN);
      idle(); mem_read_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7; use_rs2_id = 1'b1;
      rs1_id = 5'd3; use_rs1_id = 1'b1; cyc("lu_rs2", C_LOAD); e_ld = sat(e_ld);
      idle(); cyc("post_lu", C_RUN);
      load_use(5'd0); cyc("lu_x0", C_RUN);
      idle(); load_use(5'd9); use_rs1_id = 1'b0; cyc("lu_no_use", C_RUN);
      idle(); load_use(5'd9); mem_read_ex = 1'b0; cyc("lu_no_load", C_RUN);
      idle(); load_use(5'd5); mispredict_ex = 1'b1; cyc("mp_over_lu", C_FLUSH); e_fl = sat(e_fl);
      idle(); cyc("post_mp", C_RUN);

      // mc_done arrives on the busy cycle where the watchdog equals MC_TIMEOUT; done wins.
      mc_valid_ex = 1'b1; cyc("mc_entry", C_MCENT); e_mc = sat(e_mc);
      mispredict_ex = 1'b1; load_use(5'd4); cyc("mc_b1_ign_mp", C_MCBSY); e_mc = sat(e_mc);
      idle(); mc_valid_ex = 1'b1; cyc("mc_b2", C_MCBSY); e_mc = sat(e_mc);
      cyc("mc_b3", C_MCBSY); e_mc = sat(e_mc);
      mc_done = 1'b1; cyc("mc_done_exit", C_RUN);
      idle(); mc_done = 1'b1; cyc("done_in_run", C_RUN);

      idle(); mc_valid_ex = 1'b1; cyc("to_entry", C_MCENT); e_mc = sat(e_mc);
      for (int i = 0; i < MC_TIMEOUT - 1; i++) begin
         cyc("to_busy", C_MCBSY); e_mc = sat(e_mc);
      end
      cyc("to_abort", C_MCTO); e_err = 1'b1;
      idle(); cyc("post_to", C_RUN);
      load_use(5'd6); cyc("lu_after_to", C_LOAD); e_ld = sat(e_ld);

      idle(); mc_valid_ex = 1'b1; cyc("rm_entry", C_MCENT); e_mc = sat(e_mc);
      cyc("rm_b1", C_MCBSY); e_mc = sat(e_mc);
      reset = 1'b1; cyc("rst_mid_mc", C_RST); clr_all();
      idle(); cyc("run_after_rst", C_RUN);

      mc_valid_ex = 1'b1; cyc("mh_entry", C_MCENT); e_mc = sat(e_mc);
      cyc("mh_b1", C_MCBSY); e_mc = sat(e_mc);
      halt_wb = 1'b1; cyc("mh_abort", C_MCHALT); e_hlt = 1'b1;
      idle(); mc_valid_ex = 1'b1; mispredict_ex = 1'b1; cyc("halt_hold0", C_HALT);
      idle(); load_use(5'd5); cyc("halt_hold1", C_HALT);
      idle(); reset = 1'b1; cyc("rst_halt", C_RST); clr_all();
      idle(); cyc("run_after_halt", C_RUN);

      halt_wb = 1'b1; load_use(5'd5); mispredict_ex = 1'b1; cyc("run_halt", C_HALT); e_hlt = 1'b1;
      idle(); cyc("halt_sticky", C_HALT);
      reset = 1'b1; cyc("rst_final", C_RST); clr_all();
      idle(); cyc("run_final", C_RUN);

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      #1;
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
